alu_operand_loader: RTL and testbench

Front-end stage directly upstream of the 8-bit ALU in the TinyTapeout design. The 8-bit input pin bus cannot carry A, B and the operation select at once. This block time-multiplexes them: it loads them one at a time on strobes from an external pin, drives the registered operands into the combinational ALU, and captures the ALU result into a held output register with a completion pulse. It also synchronises the asynchronous strobe pin and aborts partial loads after a timeout.

---
 rtl/alu_operand_loader.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_operand_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
//
// Front end of the 8-bit ALU. The pin bus is too narrow to carry A, B and
// the operation select in one transfer, so this block loads them one at a
// time. Each load is triggered by a rising edge on the asynchronous 'load'
// pin. The block drives the registered operands into the combinational ALU
// and captures the ALU result into a held output register, together with a
// one-cycle completion pulse. If a partial A/B/op sequence stalls for longer
// than TIMEOUT enabled cycles, the block abandons it and sets a sticky error
// flag.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   ena        design enable; while low, state, counter and registers hold
//   data_in    operand / op byte from the pins
//   load       asynchronous load strobe (active-high level)
//   op_a       registered operand A to the ALU
//   op_b       registered operand B to the ALU
//   op_sel     registered operation select to the ALU
//   alu_result combinational result returned by the ALU
//   result_out captured result, held until the next capture
//   done       one-cycle pulse when result_out updates
//   busy       high whenever the FSM is not in WAIT_A
//   err        sticky timeout flag, cleared by the next accepted A load
//   stage      current FSM state encoding (debug)
// -----------------------------------------------------------------------------
module alu_operand_loader #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] data_in,
    input  logic       load,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [1:0] op_sel,
    input  logic [7:0] alu_result,
    output logic [7:0] result_out,
    output logic       done,
    output logic       busy,
    output logic       err,
    output logic [1:0] stage
);

    localparam logic [1:0] WAIT_A  = 2'd0;
    localparam logic [1:0] WAIT_B  = 2'd1;
    localparam logic [1:0] WAIT_OP = 2'd2;
    localparam logic [1:0] EXEC    = 2'd3;

    localparam logic [TO_W-1:0] TMO_LIMIT = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TMO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TMO_ZERO  = {TO_W{1'b0}};

    // Strobe synchroniser and edge detector
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   ld_pulse_s;

    // FSM, timeout counter and sticky error
    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [TO_W-1:0] tmo_r;
    logic [TO_W-1:0] tmo_nxt_s;
    logic            err_r;
    logic            err_nxt_s;

    // Register load enables decoded from the FSM
    logic load_a_s;
    logic load_b_s;
    logic load_op_s;
    logic exec_s;

    // Operand and result registers
    logic [7:0] op_a_r;
    logic [7:0] op_b_r;
    logic [1:0] op_sel_r;
    logic [7:0] result_hold_r;
    logic       result_pend_r;
    logic [7:0] result_out_r;
    logic       done_r;

    // Rising edge of the synchronised strobe: one pulse per load assertion
    assign ld_pulse_s = sync_r[SYNC_STAGES-1] & ~prev_r;

    // Synchroniser and edge flop run independently of ena
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], load};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Next-state, timeout and load-enable decode
    always_comb begin
        state_nxt_s = state_r;
        tmo_nxt_s   = tmo_r;
        err_nxt_s   = err_r;
        load_a_s    = 1'b0;
        load_b_s    = 1'b0;
        load_op_s   = 1'b0;
        exec_s      = 1'b0;
        if (ena) begin
            case (state_r)
                WAIT_A: begin
                    // No timeout while idle; counter held at zero
                    tmo_nxt_s = TMO_ZERO;
                    if (ld_pulse_s) begin
                        load_a_s    = 1'b1;
                        err_nxt_s   = 1'b0;
                        state_nxt_s = WAIT_B;
                    end else begin
                        state_nxt_s = WAIT_A;
                    end
                end
                WAIT_B, WAIT_OP: begin
                    // A strobe that coincides with the timeout wins
                    if (ld_pulse_s) begin
                        tmo_nxt_s = TMO_ZERO;
                        if (state_r == WAIT_B) begin
                            load_b_s    = 1'b1;
                            state_nxt_s = WAIT_OP;
                        end else begin
                            load_op_s   = 1'b1;
                            state_nxt_s = EXEC;
                        end
                    end else if (tmo_r == TMO_LIMIT) begin
                        // Abort the partial sequence; operands are kept
                        tmo_nxt_s   = TMO_ZERO;
                        err_nxt_s   = 1'b1;
                        state_nxt_s = WAIT_A;
                    end else begin
                        tmo_nxt_s   = tmo_r + TMO_ONE;
                        state_nxt_s = state_r;
                    end
                end
                EXEC: begin
                    // Single-cycle state; any strobe here is dropped
                    exec_s      = 1'b1;
                    tmo_nxt_s   = TMO_ZERO;
                    state_nxt_s = WAIT_A;
                end
                default: begin
                    tmo_nxt_s   = TMO_ZERO;
                    state_nxt_s = WAIT_A;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            tmo_nxt_s   = tmo_r;
            err_nxt_s   = err_r;
        end
    end

    // State, timeout counter and error flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= WAIT_A;
            tmo_r   <= TMO_ZERO;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            tmo_r   <= tmo_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Operand registers; they hold after EXEC so the ALU output stays stable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a_r   <= 8'h00;
            op_b_r   <= 8'h00;
            op_sel_r <= 2'b00;
        end else begin
            if (load_a_s) begin
                op_a_r <= data_in;
            end else begin
                op_a_r <= op_a_r;
            end
            if (load_b_s) begin
                op_b_r <= data_in;
            end else begin
                op_b_r <= op_b_r;
            end
            if (load_op_s) begin
                op_sel_r <= data_in[1:0];
            end else begin
                op_sel_r <= op_sel_r;
            end
        end
    end

    // Result capture: the ALU value is sampled in EXEC and presented one
    // cycle later, so result_out and done move two edges after the op load.
    // A reset during EXEC clears the pending capture, so no done follows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_hold_r <= 8'h00;
            result_pend_r <= 1'b0;
            result_out_r  <= 8'h00;
            done_r        <= 1'b0;
        end else if (ena) begin
            done_r <= result_pend_r;
            if (result_pend_r) begin
                result_out_r <= result_hold_r;
            end else begin
                result_out_r <= result_out_r;
            end
            if (exec_s) begin
                result_hold_r <= alu_result;
                result_pend_r <= 1'b1;
            end else begin
                result_hold_r <= result_hold_r;
                result_pend_r <= 1'b0;
            end
        end else begin
            done_r        <= 1'b0;
            result_hold_r <= result_hold_r;
            result_pend_r <= result_pend_r;
            result_out_r  <= result_out_r;
        end
    end

    assign op_a       = op_a_r;
    assign op_b       = op_b_r;
    assign op_sel     = op_sel_r;
    assign result_out = result_out_r;
    assign done       = done_r;
    assign err        = err_r;
    assign stage      = state_r;
    assign busy       = (state_r != WAIT_A);

endmodule

// File: tb/tb_alu_operand_loader.sv
// -----------------------------------------------------------------------------
// Testbench for alu_operand_loader. A cycle-level reference model tracks the
// load sequence from the raw history of the load pin and compares every
// output after every clock edge. Directed scenarios come first, followed by
// a randomized stretch.
// -----------------------------------------------------------------------------
module tb_alu_operand_loader;

    localparam int S   = 2;
    localparam int TMO = 255;
    localparam int TW  = 8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ena     = 1'b0;
    logic       load    = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] alu_result;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] op_sel;
    logic [7:0] result_out;
    logic       done;
    logic       busy;
    logic       err;
    logic [1:0] stage;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int         m_phase = 0;    // number of items loaded in the current sequence; 3 = executing
    int         m_idle  = 0;    // enabled cycles spent waiting for the next strobe
    logic [7:0] m_a     = 8'h00;
    logic [7:0] m_b     = 8'h00;
    logic [1:0] m_sel   = 2'b00;
    logic [7:0] m_res   = 8'h00;
    logic [7:0] m_hold  = 8'h00;
    logic       m_pend  = 1'b0;
    logic       m_done  = 1'b0;
    logic       m_err   = 1'b0;
    logic       hq [0:S];       // hq[k] = load sampled k+1 edges ago
    int         cyc_cnt  = 0;
    int         acc_cyc  = 0;
    int         done_cyc = -1;
    logic       done_busy = 1'b1;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] sel);
        case (sel)
            2'd0:    return a - b;
            2'd1:    return a + b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_result = alu_f(op_a, op_b, op_sel);

    alu_operand_loader #(.SYNC_STAGES(S), .TIMEOUT(TMO), .TO_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .load(load),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .alu_result(alu_result),
        .result_out(result_out), .done(done), .busy(busy), .err(err), .stage(stage)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_cnt);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT samples
    task automatic step_model();
        logic pulse;
        cyc_cnt++;
        if (!rst_n) begin
            for (int k = 0; k <= S; k++) hq[k] = 1'b0;
            m_phase = 0; m_idle = 0; m_a = 8'h00; m_b = 8'h00; m_sel = 2'b00;
            m_res = 8'h00; m_hold = 8'h00; m_pend = 1'b0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            // Rising edge of load seen S edges late
            pulse = hq[S-1] & ~hq[S];
            for (int k = S; k > 0; k--) hq[k] = hq[k-1];
            hq[0] = load;
            if (ena) begin
                m_done = m_pend;
                if (m_pend) m_res = m_hold;
                m_pend = 1'b0;
                if (m_phase == 3) begin
                    m_hold  = alu_f(m_a, m_b, m_sel);
                    m_pend  = 1'b1;
                    m_phase = 0;
                    m_idle  = 0;
                end else if (m_phase == 0) begin
                    m_idle = 0;
                    if (pulse) begin
                        m_a = data_in; m_err = 1'b0; m_phase = 1;
                    end
                end else if (pulse) begin
                    if (m_phase == 1) begin
                        m_b = data_in;
                    end else begin
                        m_sel   = data_in[1:0];
                        acc_cyc = cyc_cnt;
                    end
                    m_phase++;
                    m_idle = 0;
                end else if (m_idle == TMO) begin
                    m_phase = 0; m_err = 1'b1; m_idle = 0;
                end else begin
                    m_idle++;
                end
            end else begin
                m_done = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        step_model();
        #1;
        check("op_a",       32'(op_a),       32'(m_a));
        check("op_b",       32'(op_b),       32'(m_b));
        check("op_sel",     32'(op_sel),     32'(m_sel));
        check("result_out", 32'(result_out), 32'(m_res));
        check("done",       32'(done),       32'(m_done));
        check("busy",       32'(busy),       32'(m_phase != 0));
        check("err",        32'(err),        32'(m_err));
        check("stage",      32'(stage),      32'(m_phase));
        if (done === 1'b1) begin
            done_cyc  = cyc_cnt;
            done_busy = busy;
        end
    endtask

    task automatic strobe(input logic [7:0] d, input int hi, input int gap);
        data_in = d;
        load    = 1'b1;
        repeat (hi) cycle();
        load    = 1'b0;
        repeat (gap) cycle();
    endtask

    initial begin
        for (int k = 0; k <= S; k++) hq[k] = 1'b0;

        // Reset, then idle
        rst_n = 1'b0; ena = 1'b1;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (300) cycle();
        check("idle_err",   32'(err),   32'd0);
        check("idle_stage", 32'(stage), 32'd0);

        // Full sequence A=0x3C, B=0x05, op=1 (add)
        done_cyc = -1;
        strobe(8'h3C, 4, 6);
        strobe(8'h05, 4, 6);
        strobe(8'h01, 4, 6);
        check("seq_result",   32'(result_out), 32'h41);
        check("seq_op_a",     32'(op_a),       32'h3C);
        check("seq_op_b",     32'(op_b),       32'h05);
        check("seq_op_sel",   32'(op_sel),     32'd1);
        check("done_latency", 32'(done_cyc - acc_cyc), 32'd2);
        check("busy_at_done", 32'(done_busy),  32'd0);

        // Timeout after loading only A, then recovery by a new A
        strobe(8'h11, 4, 2);
        repeat (TMO + 2) cycle();
        check("tmo_stage", 32'(stage), 32'd0);
        check("tmo_err",   32'(err),   32'd1);
        check("tmo_op_a",  32'(op_a),  32'h11);
        strobe(8'h22, 4, 2);
        check("tmo_clr_err", 32'(err),   32'd0);
        check("tmo_clr_a",   32'(op_a),  32'h22);
        repeat (TMO + 2) cycle();

        // B strobe coinciding with the timeout cycle: the strobe wins
        strobe(8'h33, 4, 2);
        for (int i = 0; i < 400 && m_idle != TMO - S; i++) cycle();
        check("coinc_armed", 32'(m_idle), 32'(TMO - S));
        strobe(8'h44, 4, 2);
        check("coinc_stage", 32'(stage), 32'd2);
        check("coinc_err",   32'(err),   32'd0);
        check("coinc_op_b",  32'(op_b),  32'h44);

        // Enable low in WAIT_OP: strobe is lost, state holds
        ena = 1'b0;
        strobe(8'h03, 4, 4);
        check("ena_hold_stage", 32'(stage), 32'd2);
        ena = 1'b1;
        repeat (3) cycle();
        check("ena_resume_stage", 32'(stage), 32'd2);
        strobe(8'h02, 4, 6);
        check("ena_result", 32'(result_out), 32'(8'h33 & 8'h44));

        // Reset during EXEC: no done, result cleared
        strobe(8'h10, 4, 6);
        strobe(8'h20, 4, 6);
        data_in = 8'h01;
        load    = 1'b1;
        for (int i = 0; i < 10 && m_phase != 3; i++) cycle();
        check("exec_reached", 32'(stage), 32'd3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        load  = 1'b0;
        check("rst_exec_done",   32'(done),       32'd0);
        check("rst_exec_result", 32'(result_out), 32'd0);
        check("rst_exec_stage",  32'(stage),      32'd0);
        cycle();
        check("rst_exec_done2",  32'(done),       32'd0);

        // Long strobe loads only A
        repeat (4) cycle();
        data_in = 8'hAA;
        load    = 1'b1;
        repeat (40) cycle();
        load    = 1'b0;
        check("long_stage", 32'(stage), 32'd1);
        check("long_op_a",  32'(op_a),  32'hAA);
        check("long_op_b",  32'(op_b),  32'h00);

        // Randomized stretch
        for (int i = 0; i < 5000; i++) begin
            rst_n   = ($urandom_range(0, 499) != 0);
            ena     = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) == 0) load = ~load;
            data_in = 8'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
